// File: rtl/shift_pipe_unit.sv
// Elastic 32-bit barrel shifter: stages 16/8/4/2/1, each optionally registered by PIPE_MASK (latency = popcount).
// Define SHIFT_SRL_EN to build the logical-right-shift op (ctrl_op_i=2'b10); otherwise ctrl_op_i[1] is ignored.
module shift_pipe_unit #(
   parameter logic [4:0] PIPE_MASK = 5'b11111
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] data_a_i,
   input  logic [4:0]  shamt_i,
   input  logic [1:0]  ctrl_op_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] result_o,
   output logic        busy_o
);

   logic [1:0] op_in;
   logic [4:0] occ;
   logic       unused_tail;

   // The op is normalised at the input so the stages only ever see 00=SLL, 01=SRA, 10=SRL.
`ifdef SHIFT_SRL_EN
   assign op_in       = (ctrl_op_i == 2'b11) ? 2'b00 : ctrl_op_i;
   assign unused_tail = ^{g_stage[4].out_sha, g_stage[4].out_opc};
`else
   assign op_in       = {1'b0, ctrl_op_i[0]};
   assign unused_tail = ^{ctrl_op_i[1], g_stage[4].out_sha, g_stage[4].out_opc};
`endif

   for (genvar s = 0; s < 5; s++) begin : g_stage
      localparam int K   = 4 - s;
      localparam int AMT = 1 << K;

      logic        in_vld, in_rdy, out_vld, out_rdy;
      logic [31:0] in_dat, out_dat, dat_d;
      logic [4:0]  in_sha, out_sha, sha_d;
      logic [1:0]  in_opc, out_opc;

      if (s == 0) begin : g_head
         assign in_vld = in_valid_i;
         assign in_dat = data_a_i;
         assign in_sha = shamt_i;
         assign in_opc = op_in;
      end else begin : g_link
         assign in_vld = g_stage[s-1].out_vld;
         assign in_dat = g_stage[s-1].out_dat;
         assign in_sha = g_stage[s-1].out_sha;
         assign in_opc = g_stage[s-1].out_opc;
      end

      if (s == 4) begin : g_tail
         assign out_rdy = out_ready_i;
      end else begin : g_next
         assign out_rdy = g_stage[s+1].in_rdy;
      end

      // Remaining shamt travels MSB-first: bit 4 always selects this stage.
      assign sha_d = {in_sha[3:0], 1'b0};

      always_comb begin
         dat_d = in_dat;
         if (in_sha[4]) begin
            if (in_opc == 2'b01) begin
               dat_d = 32'($signed(in_dat) >>> AMT);
`ifdef SHIFT_SRL_EN
            end else if (in_opc == 2'b10) begin
               dat_d = in_dat >> AMT;
`endif
            end else begin
               dat_d = in_dat << AMT;
            end
         end
      end

      if (PIPE_MASK[K]) begin : g_reg
         logic        vld_q;
         logic [31:0] dat_q;
         logic [4:0]  sha_q;
         logic [1:0]  opc_q;

         always_ff @(posedge clock_i) begin
            if (reset_i) begin
               vld_q <= 1'b0;
               dat_q <= 32'h0;
               sha_q <= 5'h0;
               opc_q <= 2'b00;
            end else if (in_rdy) begin
               vld_q <= in_vld;
               dat_q <= dat_d;
               sha_q <= sha_d;
               opc_q <= in_opc;
            end
         end

         assign in_rdy  = !vld_q || out_rdy;
         assign out_vld = vld_q;
         assign out_dat = dat_q;
         assign out_sha = sha_q;
         assign out_opc = opc_q;
         assign occ[s]  = vld_q;
      end else begin : g_wire
         assign in_rdy  = out_rdy;
         assign out_vld = in_vld;
         assign out_dat = dat_d;
         assign out_sha = sha_d;
         assign out_opc = in_opc;
         assign occ[s]  = 1'b0;
      end
   end

   assign in_ready_o  = g_stage[0].in_rdy;
   assign out_valid_o = g_stage[4].out_vld;
   assign result_o    = g_stage[4].out_dat;
   assign busy_o      = |occ;

endmodule

// File: tb/tb_shift_pipe_unit.sv
// Directed bench for shift_pipe_unit: single-op vector table, streaming/stall, reset flush,
// and latency of the combinational and partially registered builds.
module tb_shift_pipe_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_valid0, in_valid2;
   logic [31:0] data_a;
   logic [4:0]  shamt;
   logic [1:0]  ctrl_op;
   logic        out_ready;

   logic        in_ready, out_valid, busy;
   logic [31:0] result;
   logic        in_ready0, out_valid0, busy0;
   logic [31:0] result0;
   logic        in_ready2, out_valid2, busy2;
   logic [31:0] result2;

   int checks = 0;
   int errors = 0;
   int cyc_now = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_now <= cyc_now + 1;

   shift_pipe_unit dut (
      .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .data_a_i(data_a), .shamt_i(shamt), .ctrl_op_i(ctrl_op), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .result_o(result), .busy_o(busy)
   );

   shift_pipe_unit #(.PIPE_MASK(5'b00000)) dut0 (
      .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
      .data_a_i(data_a), .shamt_i(shamt), .ctrl_op_i(ctrl_op), .out_valid_o(out_valid0),
      .out_ready_i(out_ready), .result_o(result0), .busy_o(busy0)
   );

   shift_pipe_unit #(.PIPE_MASK(5'b10100)) dut2 (
      .clock_i(clk), .reset_i(rst), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
      .data_a_i(data_a), .shamt_i(shamt), .ctrl_op_i(ctrl_op), .out_valid_o(out_valid2),
      .out_ready_i(out_ready), .result_o(result2), .busy_o(busy2)
   );

   typedef struct {
      logic [31:0] a;
      logic [4:0]  sh;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op);
`ifdef SHIFT_SRL_EN
      case (op)
         2'b01:   return 32'($signed(a) >>> sh);
         2'b10:   return a >> sh;
         default: return a << sh;
      endcase
`else
      if (op[0]) return 32'($signed(a) >>> sh);
      return a << sh;
`endif
   endfunction

   function automatic logic [31:0] gen_a(input int i);
      return 32'h9E37_79B9 * (i + 1) ^ 32'h8000_0000;
   endfunction
   function automatic logic [4:0] gen_sh(input int i);
      return 5'((i * 7 + 3) % 32);
   endfunction
   function automatic logic [1:0] gen_op(input int i);
      return 2'(i % 4);
   endfunction

   // One op through the 5-stage or 2-stage build; returns cycles from accept to out_valid.
   task automatic run_single(input bit use2, input vec_t v, input int exp_lat);
      int n;
      bit got;
      @(negedge clk);
      data_a = v.a; shamt = v.sh; ctrl_op = v.op;
      if (use2) in_valid2 = 1'b1; else in_valid = 1'b1;
      #1;
      check("accept_ready", use2 ? in_ready2 : in_ready, 1'b1);
      n = 1;
      got = 1'b0;
      while (n <= 20 && !got) begin
         @(negedge clk);
         in_valid = 1'b0; in_valid2 = 1'b0;
         if (use2 ? out_valid2 : out_valid) got = 1'b1;
         else n++;
      end
      check("latency", n, exp_lat);
      check("result", use2 ? result2 : result, v.exp);
      @(negedge clk);
      check("single_no_dup", use2 ? out_valid2 : out_valid, 1'b0);
   endtask

   task automatic stream(input int n, input int stall_at, input int stall_len, input bit chk_consec);
      int sent, recv, cyc, last, extra;
      logic [31:0] held;
      bit held_v, saw_low;
      sent = 0; recv = 0; cyc = 0; last = 0; extra = 0;
      held = '0; held_v = 1'b0; saw_low = 1'b0;
      while ((sent < n || recv < n) && cyc < 300) begin
         @(negedge clk);
         out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         if (sent < n) begin
            in_valid = 1'b1;
            data_a = gen_a(sent); shamt = gen_sh(sent); ctrl_op = gen_op(sent);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && !out_ready) begin
            if (held_v) check("stall_hold", result, held);
            held = result;
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (!out_ready && !in_ready) saw_low = 1'b1;
         if (out_valid && out_ready) begin
            check("stream_result", result, model(gen_a(recv), gen_sh(recv), gen_op(recv)));
            if (chk_consec && recv > 0) check("stream_consec", cyc_now - last, 1);
            last = cyc_now;
            recv++;
         end
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream_count", recv, n);
      repeat (8) begin
         @(negedge clk);
         if (out_valid) extra++;
      end
      check("stream_extra", extra, 0);
      if (stall_len > 0) check("stall_in_ready_low", saw_low, 1'b1);
   endtask

   initial begin
      vecs[0]  = '{32'h0000_00FF, 5'd8,  2'b00, 32'h0000_FF00};
      vecs[1]  = '{32'h8000_0000, 5'd31, 2'b01, 32'hFFFF_FFFF};
      vecs[2]  = '{32'h7000_0000, 5'd4,  2'b01, 32'h0700_0000};
      vecs[3]  = '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678};
      vecs[4]  = '{32'h8765_4321, 5'd0,  2'b01, 32'h8765_4321};
      vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF};
      vecs[6]  = '{32'hCAFE_F00D, 5'd0,  2'b11, 32'hCAFE_F00D};
      vecs[7]  = '{32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000};
`ifdef SHIFT_SRL_EN
      vecs[8]  = '{32'h8000_0000, 5'd4,  2'b10, 32'h0800_0000};
      vecs[9]  = '{32'h8000_0000, 5'd4,  2'b11, 32'h0000_0000};
`else
      vecs[8]  = '{32'h8000_0000, 5'd4,  2'b10, 32'h0000_0000};
      vecs[9]  = '{32'h8000_0000, 5'd4,  2'b11, 32'hF800_0000};
`endif
      vecs[10] = '{32'hF000_0000, 5'd1,  2'b01, 32'hF800_0000};
      vecs[11] = '{32'h0000_0001, 5'd16, 2'b00, 32'h0001_0000};
      vecs[12] = '{32'h4000_0000, 5'd30, 2'b01, 32'h0000_0001};
      vecs[13] = '{32'h8000_0000, 5'd16, 2'b01, 32'hFFFF_8000};

      rst = 1'b1;
      in_valid = 1'b0; in_valid0 = 1'b0; in_valid2 = 1'b0;
      data_a = 32'h0; shamt = 5'd0; ctrl_op = 2'b00; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_result", result, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);

      for (int i = 0; i < 14; i++) run_single(1'b0, vecs[i], 5);

      run_single(1'b1, vecs[0], 2);
      run_single(1'b1, vecs[2], 2);

      // Combinational build: valid and ready pass straight through.
      @(negedge clk);
      in_valid0 = 1'b1; data_a = 32'h0000_00FF; shamt = 5'd8; ctrl_op = 2'b00; out_ready = 1'b1;
      #1;
      check("comb_out_valid", out_valid0, 1'b1);
      check("comb_result", result0, 32'h0000_FF00);
      check("comb_in_ready_hi", in_ready0, 1'b1);
      out_ready = 1'b0;
      #1;
      check("comb_in_ready_lo", in_ready0, 1'b0);
      check("comb_busy", busy0, 1'b0);
      out_ready = 1'b1; in_valid0 = 1'b0;
      #1;
      check("comb_idle", out_valid0, 1'b0);

      stream(8, 1000, 0, 1'b1);
      stream(16, 3, 10, 1'b0);

      // Reset with three ops in flight and a fourth presented during reset.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; data_a = gen_a(i); shamt = gen_sh(i); ctrl_op = gen_op(i);
      end
      @(negedge clk);
      check("pre_rst_busy", busy, 1'b1);
      rst = 1'b1; data_a = 32'hFFFF_FFFF; shamt = 5'd0;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check("flush_out_valid", out_valid, 1'b0);
      check("flush_busy", busy, 1'b0);
      check("flush_result", result, 32'h0);
      begin
         int leaked;
         leaked = 0;
         repeat (8) begin
            @(negedge clk);
            if (out_valid) leaked++;
         end
         check("flush_no_delivery", leaked, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
